// File: rtl/seq_signed_divider_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;
    // Widest magnitude needed: a 2*WIDTH-bit most-negative dividend plus one guard bit.
    localparam int ABS_W = 2*DIV_WIDTH_DEFAULT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    // Magnitude of a sign-extended operand; the guard bit keeps -2^(n-1) from wrapping.
    function automatic logic [ABS_W-1:0] abs_w(input logic signed [ABS_W-1:0] v);
        return v[ABS_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/seq_signed_divider_if.sv
// Request/response bundle for seq_signed_divider.
// Optional DIV_ABORT_EN adds the abort request line.
interface seq_signed_divider_if #(parameter int WIDTH = 32);

    logic                   start;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
`ifdef DIV_ABORT_EN
    logic                   abort;
`endif
    logic                   busy;
    logic                   done;
    logic [WIDTH-1:0]       quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_by_zero;
    logic                   overflow;

`ifdef DIV_ABORT_EN
    modport master (output start, dividend, divisor, abort,
                    input  busy, done, quotient, remainder, div_by_zero, overflow);
    modport slave  (input  start, dividend, divisor, abort,
                    output busy, done, quotient, remainder, div_by_zero, overflow);
`else
    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder, div_by_zero, overflow);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder, div_by_zero, overflow);
`endif

endinterface

// File: rtl/seq_signed_divider_restore_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract, keep or restore.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,     // partial remainder, always < divisor magnitude
    input  logic             i_bit,     // next dividend bit, MSB first
    input  logic [WIDTH-1:0] i_dvs,     // divisor magnitude (non-zero)
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_unused_msb;

    assign w_shift      = {i_rem, i_bit};
    assign w_diff       = w_shift - {1'b0, i_dvs};
    // Result is below the divisor, so the top bit of the difference is always zero when kept.
    assign w_unused_msb = w_diff[WIDTH];

    // Trial subtraction succeeds when the shifted remainder reaches the divisor.
    always_comb begin
        o_q   = (w_shift >= {1'b0, i_dvs});
        o_rem = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Optional DIV_ABORT_EN adds an abort input that cancels an operation in CALC or FIX.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT   // at most DIV_WIDTH_DEFAULT (magnitude helper width)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_signed_divider_if.slave   div_if
);

    localparam int W2 = 2*WIDTH;
    localparam int CW = $clog2(W2) + 1;

    div_state_e         r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [W2-1:0]      r_dq;        // dividend bits shift out the top, quotient bits shift in
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_dvd_lo;    // raw low dividend bits, returned on divide-by-zero
    logic               r_neg_dvd, r_neg_q, r_dz;
    logic               r_done, r_dbz, r_ovf;
    logic [WIDTH-1:0]   r_quot, r_rem_o;

    logic [ABS_W-1:0]   w_dvd_mag, w_dvs_mag;
    logic [WIDTH-1:0]   w_step_rem;
    logic               w_step_q;
    logic [W2:0]        w_q_full;
    logic [WIDTH-1:0]   w_r_fix;
    logic               w_ovf, w_abort, w_dvs_zero;
    logic               w_unused;

`ifdef DIV_ABORT_EN
    assign w_abort = div_if.abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_dvd_mag  = abs_w(ABS_W'(signed'(div_if.dividend)));
    assign w_dvs_mag  = abs_w(ABS_W'(signed'(div_if.divisor)));
    assign w_dvs_zero = (div_if.divisor == '0);
    // Magnitudes never reach the guard bits beyond what each operand needs.
    assign w_unused   = ^{w_dvd_mag[ABS_W-1:W2], w_dvs_mag[ABS_W-1:WIDTH]};

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_bit (r_dq[W2-1]),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_q   (w_step_q)
    );

    // Sign fix; the quotient fits WIDTH bits only if its upper bits are a pure sign extension.
    assign w_q_full = r_neg_q ? -{1'b0, r_dq} : {1'b0, r_dq};
    assign w_r_fix  = r_neg_dvd ? -r_rem : r_rem;
    assign w_ovf    = !((&w_q_full[W2:WIDTH-1]) || !(|w_q_full[W2:WIDTH-1]));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state: abort wins over iteration, divide-by-zero skips CALC.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (div_if.start) w_next = w_dvs_zero ? FIX : CALC;
            CALC: if (w_abort) w_next = IDLE;
                  else if (r_cnt == CW'(W2-1)) w_next = FIX;
            FIX:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_dq      <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_dvd_lo  <= '0;
            r_neg_dvd <= 1'b0;
            r_neg_q   <= 1'b0;
            r_dz      <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
            r_quot    <= '0;
            r_rem_o   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (div_if.start) begin
                    r_dq      <= w_dvd_mag[W2-1:0];
                    r_dvs     <= w_dvs_mag[WIDTH-1:0];
                    r_rem     <= '0;
                    r_cnt     <= '0;
                    r_neg_dvd <= div_if.dividend[W2-1];
                    r_neg_q   <= div_if.dividend[W2-1] ^ div_if.divisor[WIDTH-1];
                    r_dvd_lo  <= div_if.dividend[WIDTH-1:0];
                    r_dz      <= w_dvs_zero;
                    r_dbz     <= 1'b0;
                    r_ovf     <= 1'b0;
                end
                CALC: if (!w_abort) begin
                    r_rem <= w_step_rem;
                    r_dq  <= {r_dq[W2-2:0], w_step_q};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: if (!w_abort) begin
                    r_done <= 1'b1;
                    if (r_dz) begin
                        r_quot  <= '1;
                        r_rem_o <= r_dvd_lo;
                        r_dbz   <= 1'b1;
                        r_ovf   <= 1'b0;
                    end else begin
                        r_quot  <= w_q_full[WIDTH-1:0];
                        r_rem_o <= w_r_fix;
                        r_dbz   <= 1'b0;
                        r_ovf   <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div_if.busy        = (r_state != IDLE);
    assign div_if.done        = r_done;
    assign div_if.quotient    = r_quot;
    assign div_if.remainder   = r_rem_o;
    assign div_if.div_by_zero = r_dbz;
    assign div_if.overflow    = r_ovf;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider: directed corner cases plus back-to-back random ops.
module tb_seq_signed_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    seq_signed_divider_if #(.WIDTH(32)) dif();

    seq_signed_divider #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_if (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] dvd, input logic [31:0] dvs);
        exp_t m;
        logic signed [127:0] a, b, q, r;
        if (dvs == 32'd0) begin
            m.q = 32'hFFFF_FFFF; m.r = dvd[31:0]; m.dz = 1'b1; m.ovf = 1'b0;
        end else begin
            a = 128'(signed'(dvd));
            b = 128'(signed'(dvs));
            q = a / b;
            r = a % b;
            m.q   = q[31:0];
            m.r   = r[31:0];
            m.dz  = 1'b0;
            m.ovf = (q > 128'sd2147483647) || (q < -128'sd2147483648);
        end
        return m;
    endfunction

    // Called at the negedge after the accepting edge (cycle 1); returns cycle count of done.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!dif.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", {63'd0, dif.done}, 64'd1);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_sb"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_q"},   64'(dif.quotient),    64'(e.q));
            chk({tag, "_r"},   64'(dif.remainder),   64'(e.r));
            chk({tag, "_dz"},  64'(dif.div_by_zero), 64'(e.dz));
            chk({tag, "_ovf"}, 64'(dif.overflow),    64'(e.ovf));
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] dvd, input logic [31:0] dvs,
                          input int lat);
        int cyc;
        @(negedge clk);
        dif.dividend = dvd; dif.divisor = dvs; dif.start = 1'b1;
        sb.push_back(model(dvd, dvs));
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        wait_done(cyc);
        chk({tag, "_lat"}, 64'(cyc), 64'(lat));
        check_result(tag);
        @(negedge clk);
        chk({tag, "_pulse"}, {63'd0, dif.done}, 64'd0);
    endtask

    task automatic watch_no_done(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            seen = seen | dif.done;
        end
        chk(tag, {63'd0, seen}, 64'd0);
    endtask

    localparam int NRAND = 64;
    logic [63:0] rd [NRAND];
    logic [31:0] rv [NRAND];

    initial begin
        int cyc;
        logic signed [63:0] p;
        dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
`ifdef DIV_ABORT_EN
        dif.abort = 1'b0;
`endif
        #1;
        chk("rst_busy", {63'd0, dif.busy}, 64'd0);
        chk("rst_done", {63'd0, dif.done}, 64'd0);
        chk("rst_q",    64'(dif.quotient), 64'd0);
        chk("rst_r",    64'(dif.remainder), 64'd0);
        chk("rst_dz",   {63'd0, dif.div_by_zero}, 64'd0);
        chk("rst_ovf",  {63'd0, dif.overflow}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("d30_6",   64'd30, 32'd6, 66);
        run_op("d28_m7",  64'd28, -32'sd7, 66);
        run_op("dm251_5", -64'sd251, 32'd5, 66);
        run_op("ovf_neg", -64'sd2147483648, -32'sd1, 66);
        run_op("ovf_big", 64'd1 << 40, 32'd1, 66);
        run_op("div0",    64'd1234, 32'd0, 2);
        run_op("minmin",  64'h8000_0000_0000_0000, 32'h8000_0000, 66);

        // start pulsed mid-operation must be ignored
        @(negedge clk);
        dif.dividend = 64'd1000; dif.divisor = 32'd7; dif.start = 1'b1;
        sb.push_back(model(64'd1000, 32'd7));
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin @(negedge clk); cyc++; end
        chk("busy_mid", {63'd0, dif.busy}, 64'd1);
        dif.dividend = 64'd77; dif.divisor = 32'd3; dif.start = 1'b1;
        @(negedge clk); cyc++;
        dif.start = 1'b0;
        while (!dif.done && cyc < 200) begin @(negedge clk); cyc++; end
        chk("ign_done_seen", {63'd0, dif.done}, 64'd1);
        chk("ign_lat", 64'(cyc), 64'd66);
        check_result("ign");
        watch_no_done("ign_not_queued", 80);

        // Reset in the middle of an operation
        @(negedge clk);
        dif.dividend = -64'sd99999; dif.divisor = 32'd13; dif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", {63'd0, dif.busy}, 64'd0);
        chk("mrst_q",    64'(dif.quotient), 64'd0);
        chk("mrst_r",    64'(dif.remainder), 64'd0);
        chk("mrst_ovf",  {63'd0, dif.overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_done("mrst_no_done", 80);

`ifdef DIV_ABORT_EN
        run_op("pre_abort", 64'd100, 32'd9, 66);
        @(negedge clk);
        dif.dividend = -64'sd5000; dif.divisor = 32'd3; dif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.start = 1'b0;
        repeat (29) @(negedge clk);
        dif.abort = 1'b1;
        @(negedge clk);
        dif.abort = 1'b0;
        chk("abort_busy", {63'd0, dif.busy}, 64'd0);
        watch_no_done("abort_no_done", 80);
        chk("abort_q_hold", 64'(dif.quotient), 64'd11);
        chk("abort_r_hold", 64'(dif.remainder), 64'd1);
`endif

        // Back-to-back random operations with start held through the done cycle
        for (int i = 0; i < NRAND; i++) begin
            rv[i] = $urandom;
            if (i % 8 == 3)      rv[i] = 32'd0;
            else if (i % 4 == 1) rv[i] = 32'($urandom_range(1, 20)) ^ {32{rv[i][31]}};
            if (i % 3 == 0) begin
                rd[i] = {$urandom, $urandom};
            end else begin
                p = 64'(signed'($urandom)) * 64'(signed'(rv[i]));
                rd[i] = p + 64'($urandom_range(0, 5));
            end
        end
        @(negedge clk);
        dif.dividend = rd[0]; dif.divisor = rv[0]; dif.start = 1'b1;
        sb.push_back(model(rd[0], rv[0]));
        for (int i = 0; i < NRAND; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i + 1 < NRAND) begin
                dif.dividend = rd[i+1]; dif.divisor = rv[i+1];
                sb.push_back(model(rd[i+1], rv[i+1]));
            end else begin
                dif.start = 1'b0;
            end
            wait_done(cyc);
            chk("b2b_lat", 64'(cyc), (rv[i] == 32'd0) ? 64'd2 : 64'd66);
            check_result("b2b");
        end
        dif.start = 1'b0;
        watch_no_done("tail_no_done", 80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
